scoreboard_display: RTL
=======================

# scoreboard_display

Downstream display stage for the basketball system. It samples the scoreboard values (two team scores, game minutes and seconds, shot clock) once per refresh frame and converts them to BCD with a serial double-dabble converter. It then drives a 12-digit multiplexed 7-segment display and pulses a buzzer when the shot clock or the game clock expires. All outputs are registered.

## Interface

Parameters:
- DWELL, default 8: cycles each digit stays enabled; must be ≥ 5.
- BUZZ_LEN, default 16: buzzer pulse length in cycles; must be ≥ 1.

Ports:
- clock  input  1  system clock; all logic on rising edge.
- PB0  input  1  master reset; one clock, reset is synchronous and active-high.
- score1  input  8  team 1 score, 0..255.
- score2  input  8  team 2 score, 0..255.
- minutes  input  4  game minutes, 0..15.
- seconds  input  6  game seconds, 0..63.
- shotclock  input  5  shot clock, 0..31.
- seg  output  7  segments {g,f,e,d,c,b,a}, active-high; 0 means blank.
- digit_sel  output  12  one-hot digit enable, active-high.
- buzzer  output  1  horn drive, active-high.

## Operation

Digit map (index → content):
- 0..2: score1 hundreds, tens, ones.
- 3..5: score2 hundreds, tens, ones.
- 6..7: minutes tens, ones.
- 8..9: seconds tens, ones.
- 10..11: shotclock tens, ones.

Scan:
- A digit index runs 0..11. It advances every DWELL cycles and wraps 11→0.
- One frame is 12·DWELL cycles.

Frame boundary (index wraps to 0, and the first cycle after reset release):
- The snapshot register captures all five inputs, zero-extended to 8 bits.
- The shadow BCD buffer is copied into the display buffer.
- The sequencer starts converting the new snapshot.

Sequencer FSM:
- States: IDLE → CONV(k) for k = 0..4, in order score1, score2, minutes, seconds, shotclock → IDLE.
- CONV(k) pulses start to the converter, waits for done, then writes the 3 BCD digits into shadow slot k.
- For 2-digit fields the hundreds digit is discarded; it is always 0.

Converter and frame budget:
- Converter: 1 load cycle plus 8 shift/add-3 cycles.
- 5 fields take ≤ 50 cycles, which fits inside one frame for any DWELL ≥ 5.
- Parameter check: elaborate-time error if DWELL < 5.

Leading-zero blanking:
- Scores only. Hundreds is blank when 0; tens is blank when both hundreds and tens are 0.
- Inner zeros are shown.
- Clock fields always show both digits.

Segment encoding:
- Standard 0..9 patterns: 0=0111111, 1=0000110, 2=1011011, 3=1001111, 4=1100110, 5=1101101, 6=1111101, 7=0000111, 8=1111111, 9=1101111.
- Codes 10..15 map to blank.

Buzzer:
- Events: shot-clock event is `shotclock==0`; game event is `minutes==0 && seconds==0`. Both are evaluated on live inputs every cycle.
- A rising edge of either event loads a BUZZ_LEN counter. buzzer is high while the counter is nonzero.
- A rising edge that arrives while the buzzer is active reloads the counter to BUZZ_LEN.
- Holding an event true does not retrigger.
- Edge-detect history flags reset to 1, so a condition already true at reset release does not buzz.

Reset (PB0 high at an edge; also applies mid-operation):
- Outputs: seg=0, digit_sel=0, buzzer=0.
- FSM returns to IDLE. Any in-flight conversion is aborted.
- Snapshot, shadow and display buffers are cleared to 0. Scan index → 0.

## Timing

- Cycle 0 is the first edge with PB0 low:
  - digit_sel=12'h001.
  - The display buffer is all zeros: seg=0 on indices 0,1,3,4 (blanked); index 2 shows "0".
- Frame 0 always shows zeros. Values sampled at the start of frame N are displayed throughout frame N+1, a 1-frame latency.
- seg and digit_sel change on the same edge. There is no blank gap between digits.
- Converter handshake: start is a 1-cycle pulse at cycle t; done is a 1-cycle pulse at t+9 with bcd valid. start is ignored while the converter is busy.
- Buzzer: the input edge occurs at edge t; buzzer goes high at t+1 and stays high for exactly BUZZ_LEN cycles.

## Structure

Package scoreboard_pkg holds:
- NUM_DIGITS=12.
- Field index constants: F_SCORE1..F_SHOT.
- The digit-index → (field, position) mapping.
- A 7-seg encode function and a BLANK constant.

Sub-module bin2bcd_seq:
- 8-bit serial double-dabble converter.
- Ports: clock, PB0, start, bin[7:0], busy, done, bcd[11:0].

## Test plan

All scenarios use DWELL=8 and BUZZ_LEN=16 unless stated.

1. Static inputs score1=7, score2=105, minutes=12, seconds=59, shotclock=24 after reset → frame 0 shows blank,blank,0 per score and 00 clocks; frame 1 shows [blank,blank,7][1,0,5][1,2][5,9][2,4]; index 2 seg=0000111.
2. Scan check → digit_sel is one-hot, each index held exactly 8 cycles, order 0..11, wrap at cycle 96, never all-zero after reset.
3. score1 changes 7→8 at cycle 40 of frame N → frames N and N+1 show 7; frame N+2 shows 8.
4. Score boundaries: 255 → 2,5,5; 0 → blank,blank,0; 100 → 1,0,0; 9 → blank,blank,9.
5. Buzzer:
   - shotclock 1→0 → buzzer high for exactly 16 cycles; holding 0 gives no retrigger.
   - seconds 1→0 with minutes=0, 5 cycles into the pulse → pulse extends to 21 cycles total.
   - Reset with shotclock=0 → no buzz.
6. PB0 asserted for 1 cycle at cycle 20 of the first frame, mid-conversion → next edge seg=0, digit_sel=0, buzzer=0; after release the Scenario 1 sequence repeats exactly.

Source files
------------

// File: rtl/scoreboard_pkg.sv
// Shared definitions for the scoreboard display stage.
//   - field indices for the five sampled scoreboard values
//   - digit index -> (field, BCD position) mapping for the 12-digit display
//   - 7-segment encoder and the blank pattern
//   - sequencer state type
package scoreboard_pkg;

    localparam int unsigned NUM_DIGITS = 12;
    localparam int unsigned NUM_FIELDS = 5;

    localparam logic [2:0] F_SCORE1  = 3'd0;
    localparam logic [2:0] F_SCORE2  = 3'd1;
    localparam logic [2:0] F_MINUTES = 3'd2;
    localparam logic [2:0] F_SECONDS = 3'd3;
    localparam logic [2:0] F_SHOT    = 3'd4;

    localparam logic [1:0] POS_HUNDREDS = 2'd0;
    localparam logic [1:0] POS_TENS     = 2'd1;
    localparam logic [1:0] POS_ONES     = 2'd2;

    // Segment order {g,f,e,d,c,b,a}, active-high.
    localparam logic [6:0] BLANK = 7'b0000000;

    typedef enum logic [1:0] {StIdle, StLoad, StWait} seq_state_e;

    function automatic logic [2:0] digit_field(input logic [3:0] idx);
        logic [2:0] f;
        case (idx)
            4'd0, 4'd1, 4'd2: f = F_SCORE1;
            4'd3, 4'd4, 4'd5: f = F_SCORE2;
            4'd6, 4'd7:       f = F_MINUTES;
            4'd8, 4'd9:       f = F_SECONDS;
            default:          f = F_SHOT;
        endcase
        return f;
    endfunction

    // Clock fields occupy even/odd pairs starting at 6: even is tens, odd is ones.
    function automatic logic [1:0] digit_pos(input logic [3:0] idx);
        logic [1:0] p;
        case (idx)
            4'd0, 4'd3: p = POS_HUNDREDS;
            4'd1, 4'd4: p = POS_TENS;
            4'd2, 4'd5: p = POS_ONES;
            default:    p = idx[0] ? POS_ONES : POS_TENS;
        endcase
        return p;
    endfunction

    function automatic logic [6:0] seg_encode(input logic [3:0] d);
        logic [6:0] s;
        case (d)
            4'd0:    s = 7'b0111111;
            4'd1:    s = 7'b0000110;
            4'd2:    s = 7'b1011011;
            4'd3:    s = 7'b1001111;
            4'd4:    s = 7'b1100110;
            4'd5:    s = 7'b1101101;
            4'd6:    s = 7'b1111101;
            4'd7:    s = 7'b0000111;
            4'd8:    s = 7'b1111111;
            4'd9:    s = 7'b1101111;
            default: s = BLANK;
        endcase
        return s;
    endfunction

endpackage

// File: rtl/bin2bcd_seq.sv
// Serial 8-bit binary to 3-digit BCD converter (double-dabble).
//   clock  : system clock
//   PB0    : synchronous active-high reset, aborts any conversion
//   start  : 1-cycle request, ignored while busy
//   bin    : binary value, sampled when start is accepted
//   busy   : conversion in progress
//   done   : 1-cycle pulse, 9 cycles after start, with bcd valid
//   bcd    : {hundreds, tens, ones}, held until the next done
module bin2bcd_seq (
    input  logic        clock,
    input  logic        PB0,
    input  logic        start,
    input  logic [7:0]  bin,
    output logic        busy,
    output logic        done,
    output logic [11:0] bcd
);

    logic [7:0]  r_bin;
    logic [11:0] r_acc;
    logic [2:0]  r_cnt;
    logic        r_busy;
    logic        r_done;
    logic [11:0] r_bcd;

    logic [11:0] w_adj;
    logic [19:0] w_shift;

    // Add-3 on every digit that would overflow past 9 after the next shift.
    always_comb begin
        w_adj = r_acc;
        for (int i = 0; i < 3; i++) begin
            if (r_acc[4*i +: 4] >= 4'd5) begin
                w_adj[4*i +: 4] = r_acc[4*i +: 4] + 4'd3;
            end
        end
        w_shift = {w_adj, r_bin} << 1;
    end

    always_ff @(posedge clock) begin
        if (PB0) begin
            r_bin  <= '0;
            r_acc  <= '0;
            r_cnt  <= '0;
            r_busy <= 1'b0;
            r_done <= 1'b0;
            r_bcd  <= '0;
        end else begin
            r_done <= 1'b0;
            if (!r_busy) begin
                if (start) begin
                    r_bin  <= bin;
                    r_acc  <= '0;
                    r_cnt  <= '0;
                    r_busy <= 1'b1;
                end
            end else begin
                r_acc <= w_shift[19:8];
                r_bin <= w_shift[7:0];
                r_cnt <= r_cnt + 3'd1;
                if (r_cnt == 3'd7) begin
                    r_busy <= 1'b0;
                    r_done <= 1'b1;
                    r_bcd  <= w_shift[19:8];
                end
            end
        end
    end

    assign busy = r_busy;
    assign done = r_done;
    assign bcd  = r_bcd;

endmodule

// File: rtl/scoreboard_display.sv
// Scoreboard display stage: samples five scoreboard values once per frame, converts
// them to BCD serially, scans a 12-digit multiplexed 7-segment display and drives a
// buzzer on shot-clock / game-clock expiry. All outputs are registered.
//   clock            : system clock
//   PB0              : synchronous active-high reset
//   score1, score2   : team scores 0..255
//   minutes, seconds : game clock
//   shotclock        : shot clock
//   seg              : {g,f,e,d,c,b,a}, active-high, 0 = blank
//   digit_sel        : one-hot digit enable
//   buzzer           : horn drive
module scoreboard_display
    import scoreboard_pkg::*;
#(
    parameter int unsigned DWELL    = 8,
    parameter int unsigned BUZZ_LEN = 16
) (
    input  logic        clock,
    input  logic        PB0,
    input  logic [7:0]  score1,
    input  logic [7:0]  score2,
    input  logic [3:0]  minutes,
    input  logic [5:0]  seconds,
    input  logic [4:0]  shotclock,
    output logic [6:0]  seg,
    output logic [11:0] digit_sel,
    output logic        buzzer
);

    localparam int unsigned CW = $clog2(DWELL);
    localparam int unsigned BW = $clog2(BUZZ_LEN + 1);

    // Five conversions of 10 cycles each must finish within one 12*DWELL frame.
    if (DWELL < 5) begin : g_dwell_check
        $error("scoreboard_display: DWELL must be at least 5");
    end
    if (BUZZ_LEN < 1) begin : g_buzz_check
        $error("scoreboard_display: BUZZ_LEN must be at least 1");
    end

    // Scan: r_run is low only before the first post-reset edge, which starts a frame.
    logic          r_run;
    logic [3:0]    r_idx;
    logic [CW-1:0] r_cnt;
    logic [3:0]    w_idx_next;
    logic [CW-1:0] w_cnt_next;
    logic          w_frame_start;

    always_comb begin
        w_idx_next    = r_idx;
        w_cnt_next    = r_cnt + CW'(1);
        w_frame_start = 1'b0;
        if (!r_run) begin
            w_idx_next    = '0;
            w_cnt_next    = '0;
            w_frame_start = 1'b1;
        end else if (r_cnt == CW'(DWELL - 1)) begin
            w_cnt_next = '0;
            if (r_idx == 4'(NUM_DIGITS - 1)) begin
                w_idx_next    = '0;
                w_frame_start = 1'b1;
            end else begin
                w_idx_next = r_idx + 4'd1;
            end
        end
    end

    // Snapshot, shadow BCD and display buffers, one slot per field.
    logic [NUM_FIELDS-1:0][7:0]  r_snap;
    logic [NUM_FIELDS-1:0][11:0] r_shadow;
    logic [NUM_FIELDS-1:0][11:0] r_disp;
    logic [NUM_FIELDS-1:0][11:0] w_disp_next;

    // Sequencer
    seq_state_e  r_state;
    seq_state_e  w_state_next;
    logic [2:0]  r_field;
    logic [2:0]  w_field_next;
    logic        w_conv_start;
    logic        w_shadow_we;
    logic        w_conv_busy;
    logic        w_conv_done;
    logic [7:0]  w_conv_bin;
    logic [11:0] w_conv_bcd;

    assign w_conv_bin = r_snap[r_field];

    always_comb begin
        w_state_next = r_state;
        w_field_next = r_field;
        w_conv_start = 1'b0;
        w_shadow_we  = 1'b0;
        unique case (r_state)
            StIdle: begin
                if (w_frame_start) begin
                    w_state_next = StLoad;
                    w_field_next = F_SCORE1;
                end
            end
            StLoad: begin
                w_conv_start = !w_conv_busy;
                if (!w_conv_busy) begin
                    w_state_next = StWait;
                end
            end
            StWait: begin
                if (w_conv_done) begin
                    w_shadow_we = 1'b1;
                    if (r_field == F_SHOT) begin
                        w_state_next = StIdle;
                    end else begin
                        w_field_next = r_field + 3'd1;
                        w_state_next = StLoad;
                    end
                end
            end
            default: w_state_next = StIdle;
        endcase
    end

    bin2bcd_seq u_conv (
        .clock (clock),
        .PB0   (PB0),
        .start (w_conv_start),
        .bin   (w_conv_bin),
        .busy  (w_conv_busy),
        .done  (w_conv_done),
        .bcd   (w_conv_bcd)
    );

    // Digit selection works from the buffer contents as they will be after this edge,
    // so the first digit of a new frame already shows the freshly copied values.
    logic [2:0]  w_field;
    logic [1:0]  w_pos;
    logic [11:0] w_word;
    logic [3:0]  w_digit;
    logic        w_blank;
    logic        w_is_score;
    logic [6:0]  w_seg_next;

    always_comb begin
        w_disp_next = w_frame_start ? r_shadow : r_disp;
        w_field     = digit_field(w_idx_next);
        w_pos       = digit_pos(w_idx_next);
        w_word      = w_disp_next[w_field];
        w_is_score  = (w_field == F_SCORE1) || (w_field == F_SCORE2);
        unique case (w_pos)
            POS_HUNDREDS: w_digit = w_word[11:8];
            POS_TENS:     w_digit = w_word[7:4];
            default:      w_digit = w_word[3:0];
        endcase
        w_blank = w_is_score &&
                  (((w_pos == POS_HUNDREDS) && (w_word[11:8] == 4'd0)) ||
                   ((w_pos == POS_TENS) && (w_word[11:4] == 8'd0)));
        w_seg_next = w_blank ? BLANK : seg_encode(w_digit);
    end

    // Buzzer: rising edges of either event (re)load the pulse counter.
    logic          r_shot_prev;
    logic          r_game_prev;
    logic [BW-1:0] r_buzz_cnt;
    logic [BW-1:0] w_buzz_next;
    logic          w_shot_ev;
    logic          w_game_ev;
    logic          w_rise;

    always_comb begin
        w_shot_ev = (shotclock == 5'd0);
        w_game_ev = (minutes == 4'd0) && (seconds == 6'd0);
        w_rise    = (w_shot_ev && !r_shot_prev) || (w_game_ev && !r_game_prev);
        if (w_rise) begin
            w_buzz_next = BW'(BUZZ_LEN);
        end else if (r_buzz_cnt != '0) begin
            w_buzz_next = r_buzz_cnt - BW'(1);
        end else begin
            w_buzz_next = '0;
        end
    end

    logic [6:0]  r_seg;
    logic [11:0] r_digit_sel;
    logic        r_buzzer;

    always_ff @(posedge clock) begin
        if (PB0) begin
            r_run       <= 1'b0;
            r_idx       <= '0;
            r_cnt       <= '0;
            r_snap      <= '0;
            r_shadow    <= '0;
            r_disp      <= '0;
            r_state     <= StIdle;
            r_field     <= F_SCORE1;
            r_shot_prev <= 1'b1;
            r_game_prev <= 1'b1;
            r_buzz_cnt  <= '0;
            r_seg       <= BLANK;
            r_digit_sel <= '0;
            r_buzzer    <= 1'b0;
        end else begin
            r_run   <= 1'b1;
            r_idx   <= w_idx_next;
            r_cnt   <= w_cnt_next;
            r_state <= w_state_next;
            r_field <= w_field_next;
            if (w_frame_start) begin
                r_snap <= {{3'b000, shotclock}, {2'b00, seconds}, {4'b0000, minutes},
                           score2, score1};
            end
            if (w_shadow_we) begin
                r_shadow[r_field] <= w_conv_bcd;
            end
            r_disp      <= w_disp_next;
            r_shot_prev <= w_shot_ev;
            r_game_prev <= w_game_ev;
            r_buzz_cnt  <= w_buzz_next;
            r_seg       <= w_seg_next;
            r_digit_sel <= 12'd1 << w_idx_next;
            r_buzzer    <= (w_buzz_next != '0);
        end
    end

    assign seg       = r_seg;
    assign digit_sel = r_digit_sel;
    assign buzzer    = r_buzzer;

endmodule
